// File: rtl/recv_addr.sv
// recv_addr: 8N1 serial receiver that turns lines of five hex digits + LF into a
// 20-bit address read out through a Wishbone read-only slave. RECV_ADDR_ERR_EN adds port err.
module recv_addr #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rrx_,
    output logic [19:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o
`ifdef RECV_ADDR_ERR_EN
    ,
    output logic        err
`endif
);

    // state | meaning
    // IDLE  | line idle, waiting for a falling edge
    // START | timing to mid start bit, rejects glitches
    // DATA  | sampling 8 data bits, LSB first
    // STOP  | sampling stop bit, strobes byte when high
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    localparam logic [11:0] FULL_M1 = 12'(CLKS_PER_BIT - 1);
    localparam logic [11:0] HALF_M1 = 12'(CLKS_PER_BIT / 2 - 1);

    logic        rx_meta;
    logic        rx_sync;
    rx_state_t   state;
    logic [11:0] bit_tmr;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;
    logic [7:0]  byte_q;
    logic        byte_stb;

    logic [19:0] acc;
    logic [2:0]  dig_cnt;
    logic        line_bad;
    logic        valid;
    logic [19:0] dat_hold;
    logic        dat_pend;

    logic        is_hex;
    logic [3:0]  nib;
    logic        commit;
    logic        rd_req;
    logic        ack_fire;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rrx_;
            rx_sync <= rx_meta;
        end
    end

`ifdef RECV_ADDR_ERR_EN
    logic frame_err;
`endif

    // Bit timer is a down-counter; every sample happens at terminal count zero.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state    <= S_IDLE;
            bit_tmr  <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            byte_stb <= 1'b0;
`ifdef RECV_ADDR_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            byte_stb <= 1'b0;
`ifdef RECV_ADDR_ERR_EN
            frame_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!rx_sync) begin
                        state   <= S_START;
                        bit_tmr <= HALF_M1;
                    end
                end
                S_START: begin
                    if (bit_tmr == 12'd0) begin
                        if (!rx_sync) begin
                            state   <= S_DATA;
                            bit_tmr <= FULL_M1;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_tmr <= bit_tmr - 12'd1;
                    end
                end
                S_DATA: begin
                    if (bit_tmr == 12'd0) begin
                        shift_q <= {rx_sync, shift_q[7:1]};
                        bit_tmr <= FULL_M1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_tmr <= bit_tmr - 12'd1;
                    end
                end
                S_STOP: begin
                    if (bit_tmr == 12'd0) begin
                        state <= S_IDLE;
                        if (rx_sync) begin
                            byte_stb <= 1'b1;
                            byte_q   <= shift_q;
                        end
`ifdef RECV_ADDR_ERR_EN
                        else begin
                            frame_err <= 1'b1;
                        end
`endif
                    end else begin
                        bit_tmr <= bit_tmr - 12'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Letters map through their low nibble: 'a'/'A' have low nibble 1, plus 9 gives 10.
    always_comb begin
        is_hex = 1'b0;
        nib    = 4'h0;
        if (byte_q >= 8'h30 && byte_q <= 8'h39) begin
            is_hex = 1'b1;
            nib    = byte_q[3:0];
        end else if ((byte_q >= 8'h61 && byte_q <= 8'h66) ||
                     (byte_q >= 8'h41 && byte_q <= 8'h46)) begin
            is_hex = 1'b1;
            nib    = byte_q[3:0] + 4'd9;
        end
    end

    assign commit   = byte_stb && (byte_q == 8'h0a) && (dig_cnt == 3'd5) && !line_bad;
    assign rd_req   = wb_stb_i && wb_cyc_i && !wb_we_i;
    assign ack_fire = rd_req && valid && !wb_ack_o;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            acc      <= '0;
            dig_cnt  <= '0;
            line_bad <= 1'b0;
        end else if (byte_stb) begin
            if (is_hex) begin
                acc <= {acc[15:0], nib};
                if (dig_cnt != 3'd6) begin
                    dig_cnt <= dig_cnt + 3'd1;
                end
            end else if (byte_q == 8'h0a) begin
                acc      <= '0;
                dig_cnt  <= '0;
                line_bad <= 1'b0;
            end else if (byte_q != 8'h0d) begin
                line_bad <= 1'b1;
            end
        end
    end

    // A commit landing on the ack edge is parked one cycle so the ack carries the old address.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            valid    <= 1'b0;
            dat_hold <= '0;
            dat_pend <= 1'b0;
        end else begin
            wb_ack_o <= ack_fire;
            if (commit) begin
                valid <= 1'b1;
            end else if (ack_fire) begin
                valid <= 1'b0;
            end
            if (commit && ack_fire) begin
                dat_hold <= acc;
                dat_pend <= 1'b1;
            end else if (commit) begin
                wb_dat_o <= acc;
                dat_pend <= 1'b0;
            end else if (dat_pend) begin
                wb_dat_o <= dat_hold;
                dat_pend <= 1'b0;
            end
        end
    end

`ifdef RECV_ADDR_ERR_EN
    logic line_malformed;
    assign line_malformed = byte_stb && (byte_q == 8'h0a) && ((dig_cnt != 3'd5) || line_bad);

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            err <= 1'b0;
        end else if (frame_err || line_malformed) begin
            err <= 1'b1;
        end else if (ack_fire) begin
            err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_recv_addr.sv
// Bench for recv_addr: table of lines, hand-written corner sequences and random lines
// checked against a line-level model of the hex parser.
module tb_recv_addr;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rrx_ = 1'b1;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic [19:0] dat;
    logic        ack;
`ifdef RECV_ADDR_ERR_EN
    logic        err_w;
`endif

    int vectors = 0;
    int miscompares = 0;
    int ack_seen = 0;
    logic [19:0] ack_dat = '0;

    always #5 clk = ~clk;

    recv_addr #(.CLKS_PER_BIT(CPB)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .rrx_     (rrx_),
        .wb_dat_o (dat),
        .wb_we_i  (we),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc),
        .wb_ack_o (ack)
`ifdef RECV_ADDR_ERR_EN
        ,
        .err      (err_w)
`endif
    );

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            ack_seen++;
            ack_dat = dat;
        end
    end

    typedef struct {
        string       text;
        bit          commit;
        logic [19:0] val;
    } line_vec_t;

    line_vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_err(input string name, input bit exp);
`ifdef RECV_ADDR_ERR_EN
        check(name, {31'd0, err_w}, {31'd0, exp});
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rrx_ = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rrx_ = b[i];
            repeat (CPB) @(negedge clk);
        end
        rrx_ = stop_ok;
        repeat (CPB) @(negedge clk);
        rrx_ = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_q(input byte q[$]);
        foreach (q[i]) send_byte(q[i], 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wb_read(input string name, input logic [19:0] exp);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0;
        @(negedge clk);
        check({name, "_ack"}, {31'd0, ack}, 32'd1);
        check({name, "_data"}, {12'd0, dat}, {12'd0, exp});
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        check({name, "_ack_low"}, {31'd0, ack}, 32'd0);
    endtask

    task automatic wb_stall(input string name, input int n, input bit write);
        int start;
        @(negedge clk);
        start = ack_seen;
        stb = 1'b1; cyc = 1'b1; we = write;
        repeat (n) @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        check({name, "_noack"}, ack_seen - start, 32'd0);
    endtask

    function automatic int hex_val(input byte c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // Line-level model: a line commits iff it holds exactly five hex digits and nothing but CR.
    function automatic void model_line(input byte q[$], output bit ok, output logic [19:0] v);
        int  n = 0;
        bit  bad = 1'b0;
        int  val = 0;
        foreach (q[i]) begin
            if (hex_val(q[i]) >= 0) begin
                val = val * 16 + hex_val(q[i]);
                n++;
            end else if (q[i] != 8'h0d && q[i] != 8'h0a) begin
                bad = 1'b1;
            end
        end
        ok = (n == 5) && !bad;
        v  = 20'(val);
    endfunction

    initial begin
        int          s;
        bit          ok;
        logic [19:0] v;
        byte         q[$];
        string       hexs;
        string       junk;

        tbl[0] = '{"1234\n", 1'b0, 20'h0};
        tbl[1] = '{"123456\n", 1'b0, 20'h0};
        tbl[2] = '{"12g45\n", 1'b0, 20'h0};
        tbl[3] = '{"ABCDE\n", 1'b1, 20'habcde};
        tbl[4] = '{"0a\0151b2\n", 1'b1, 20'h0a1b2};
        tbl[5] = '{"fFfFf\n", 1'b1, 20'hfffff};
        tbl[6] = '{"\n", 1'b0, 20'h0};
        tbl[7] = '{"98-765\n", 1'b0, 20'h0};
        tbl[8] = '{"00000\n", 1'b1, 20'h00000};

        repeat (3) @(negedge clk);
        check("rst_dat", {12'd0, dat}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check_err("rst_err", 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // first line, write attempt ignored, read, then stall
        send_str("3fA0c\n");
        wb_stall("t1_write", 5, 1'b1);
        wb_read("t1", 20'h3fa0c);
        wb_stall("t1_second", 40, 1'b0);

        // read pending before the line arrives; held strobe must see a single ack
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0;
        s = ack_seen;
        send_str("00001\015");
        check("t2_stall", ack_seen - s, 32'd0);
        send_str("\n");
        repeat (2) @(negedge clk);
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        check("t2_one_ack", ack_seen - s, 32'd1);
        check("t2_data", {12'd0, ack_dat}, 32'h00001);

        foreach (tbl[i]) begin
            send_str(tbl[i].text);
            if (tbl[i].commit) begin
                wb_read($sformatf("tbl%0d", i), tbl[i].val);
                check_err($sformatf("tbl%0d_err_clr", i), 1'b0);
            end else begin
                check_err($sformatf("tbl%0d_err_set", i), 1'b1);
                wb_stall($sformatf("tbl%0d", i), 20, 1'b0);
            end
        end

        // framing error inside a line: the bad byte is dropped, not counted
        send_byte("1", 1'b1);
        send_byte("2", 1'b1);
        send_byte(8'h31, 1'b0);
        repeat (20) @(negedge clk);
        check_err("frame_err", 1'b1);
        send_str("345\n");
        wb_read("frame_line", 20'h12345);
        check_err("frame_err_clr", 1'b0);

        // short low glitch must not produce a byte
        rrx_ = 1'b0;
        repeat (4) @(negedge clk);
        rrx_ = 1'b1;
        repeat (40) @(negedge clk);
        send_str("5a5a5\n");
        wb_read("glitch_line", 20'h5a5a5);

        // overrun: latest line wins
        send_str("11111\n22222\n");
        wb_read("overrun", 20'h22222);
        wb_stall("overrun_second", 20, 1'b0);

        // reset in the middle of the third character of a line
        send_str("77777\n98");
        rrx_ = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rrx_ = (i == 1);
            repeat (CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        rrx_ = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_dat", {12'd0, dat}, 32'd0);
        check("midrst_ack", {31'd0, ack}, 32'd0);
        check_err("midrst_err", 1'b0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        wb_stall("midrst", 20, 1'b0);
        send_str("45678\n");
        wb_read("post_rst", 20'h45678);

        // random lines against the model
        hexs = "0123456789abcdefABCDEF";
        junk = " gxz-.";
        for (int n = 0; n < 10; n++) begin
            int len;
            q.delete();
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 7)) : 5;
            for (int k = 0; k < len; k++) begin
                q.push_back(hexs[$urandom_range(0, 21)]);
                if ($urandom_range(0, 9) == 0) q.push_back(junk[$urandom_range(0, 5)]);
                if ($urandom_range(0, 7) == 0) q.push_back(8'h0d);
            end
            q.push_back(8'h0a);
            model_line(q, ok, v);
            send_q(q);
            if (ok) begin
                wb_read($sformatf("rnd%0d", n), v);
                check_err($sformatf("rnd%0d_err_clr", n), 1'b0);
            end else begin
                check_err($sformatf("rnd%0d_err_set", n), 1'b1);
                wb_stall($sformatf("rnd%0d", n), 20, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
